dc_tag_array: RTL
=================

# dc_tag_array

Parametrised tag/valid/dirty store for the data cache, generalising the fixed 32-set, 8-bit tag store. It adds a registered lookup with on-chip tag compare and hit/dirty/victim reporting, encoded write operations, a post-reset clear sweep, and a flush engine that walks every set and hands dirty victims to the write-back path over a valid/ready handshake. It sits between the D-cache control FSM and the write-back buffer.

## Interface
- NUM_SETS, 32, number of sets; must be a power of two and at least 2.
- TAG_W, 6, tag width in bits.
- IDX_W, 5, index width; must equal log2(NUM_SETS).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lk_valid  in  1  lookup request.
- lk_index  in  IDX_W  lookup set.
- lk_tag  in  TAG_W  lookup tag.
- lk_ready  out  1  high only in IDLE; lookups are accepted only when it is high.
- hit_valid  out  1  lookup result strobe.
- hit  out  1  stored entry valid and its tag equals lk_tag.
- hit_dirty  out  1  dirty bit of the addressed entry.
- victim_tag  out  TAG_W  stored tag of the addressed entry.
- wr_op  in  2  00 none; 01 fill (tag=wr_tag, valid=1, dirty=wr_dirty); 10 set dirty; 11 invalidate.
- wr_index  in  IDX_W  write set.
- wr_tag  in  TAG_W  fill tag.
- wr_dirty  in  1  dirty bit written on fill.
- flush_req  in  1  single-cycle flush request pulse.
- flush_busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse when a flush completes.
- wb_valid  out  1  dirty victim presented to the write-back path.
- wb_index  out  IDX_W  set of the victim.
- wb_tag  out  TAG_W  tag of the victim.
- wb_ready  in  1  write-back path accepts the victim.
- parity_err  out  1  parity error pulse; present only when DC_TAG_PARITY_EN is defined.

## Operation
- Storage is a flop array of NUM_SETS entries, each {valid, dirty, tag}. Reads are combinational inside the block.
- FSM states: INIT, IDLE, FL_SCAN, FL_WB.
- INIT (entered on reset):
  - Clears valid and dirty of set `cnt` each cycle.
  - After set NUM_SETS-1 is cleared, goes to IDLE.
  - A flush_req seen during INIT is latched and starts FL_SCAN immediately after INIT.
- IDLE:
  - A lookup with lk_valid=1 registers hit, hit_dirty and victim_tag and pulses hit_valid on the next cycle.
  - hit_dirty and victim_tag are reported whether or not the lookup hits.
  - wr_op executes at the edge.
  - Set dirty (10) on an entry with valid=0 has no effect.
  - Lookup and write in the same cycle to the same set: the lookup returns the pre-write contents.
  - flush_req moves the FSM to FL_SCAN with cnt=0. If flush_req and a write arrive in the same cycle, the write executes first.
- FL_SCAN, for entry `cnt`:
  - If valid&dirty: go to FL_WB.
  - Otherwise: clear the entry. If cnt=NUM_SETS-1, go to IDLE and pulse flush_done; else increment cnt.
- FL_WB:
  - wb_valid=1, with wb_index=cnt and wb_tag equal to the stored tag, all held stable until wb_ready=1.
  - On the edge where wb_ready=1: clear the entry, drop wb_valid, then advance exactly as FL_SCAN does.
- Outside IDLE, lk_valid, wr_op and flush_req are ignored, except the flush_req latched during INIT.
- cnt is IDX_W bits and does not wrap during a sweep; the final-set test ends the sweep.

## Timing
- Reset values:
  - lk_ready=0 (the FSM is in INIT).
  - hit_valid=0, hit=0, hit_dirty=0, victim_tag=0.
  - flush_busy=0, flush_done=0.
  - wb_valid=0, wb_index=0, wb_tag=0.
  - parity_err=0, cnt=0.
- INIT lasts NUM_SETS cycles after rst_n deasserts; lk_ready rises on the following cycle.
- Lookup latency is 1 cycle. Throughput is one lookup per cycle.
- A write is visible to a lookup issued in the cycle after the write.
- Flush cost:
  - Each clean or invalid set takes 1 cycle.
  - Each dirty set takes 1 FL_SCAN cycle plus all FL_WB cycles up to and including the cycle where wb_ready=1 (at least 1).
- flush_busy is high throughout FL_SCAN and FL_WB.
- flush_done pulses in the cycle after the FSM returns to IDLE.
- Asserting rst_n low at any time, including mid-flush with wb_valid high, immediately forces all reset values and returns the FSM to INIT. The aborted flush is not resumed.

## Configuration
- DC_TAG_PARITY_EN defined:
  - Each entry stores an even-parity bit over {valid, dirty, tag}, written on fill, set dirty, invalidate and clear.
  - A lookup whose entry fails parity returns hit=0 and pulses parity_err together with hit_valid.
  - During a flush, an entry that fails parity is cleared without write-back and parity_err pulses.
- DC_TAG_PARITY_EN undefined: no parity storage, no parity_err port, and identical behaviour otherwise.

## Test plan
- Reset, then wait NUM_SETS=32 cycles -> lk_ready rises; a lookup of every set returns hit=0, hit_dirty=0.
- Fill set 5 with tag 0x2A, then look up set 5 with tag 0x2A -> hit=1, hit_dirty=0 one cycle later; look up with tag 0x15 -> hit=0, victim_tag=0x2A.
- Fill set 5 and look up set 5 with tag 0x2A in the same cycle -> hit=0; repeat the lookup the next cycle -> hit=1.
- Make sets 3 and 30 dirty, then flush with wb_ready held low 4 cycles per victim -> wb_valid for index 3 then index 30, wb_tag stable while stalled, flush_done after 32+2×5 cycles, all sets invalid afterwards.
- Drop rst_n while wb_valid=1 mid-flush -> all outputs return to reset values at once and INIT restarts.
- With DC_TAG_PARITY_EN, corrupt the stored tag of a filled set, then look up its original tag -> hit=0 and parity_err=1 on the same cycle as hit_valid.

Source files
------------

// File: rtl/dc_tag_if.sv
`default_nettype none
// ============================================================================
// Module   : dc_tag_if
// Purpose  : Bundles the lookup, write, flush and write-back signals that run
//            between the D-cache control FSM / write-back buffer (master) and
//            the tag store (slave).
// Signals  : lookup  - lk_valid, lk_index, lk_tag -> lk_ready, hit_valid, hit,
//                      hit_dirty, victim_tag
//            write   - wr_op, wr_index, wr_tag, wr_dirty
//            flush   - flush_req -> flush_busy, flush_done
//            victims - wb_valid, wb_index, wb_tag <- wb_ready
// Revision : 1.0  initial release
// ============================================================================
interface dc_tag_if #(
   parameter int TAG_W = 6,
   parameter int IDX_W = 5
);
   logic             lk_valid;
   logic [IDX_W-1:0] lk_index;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_ready;
   logic             hit_valid;
   logic             hit;
   logic             hit_dirty;
   logic [TAG_W-1:0] victim_tag;
   logic [1:0]       wr_op;
   logic [IDX_W-1:0] wr_index;
   logic [TAG_W-1:0] wr_tag;
   logic             wr_dirty;
   logic             flush_req;
   logic             flush_busy;
   logic             flush_done;
   logic             wb_valid;
   logic [IDX_W-1:0] wb_index;
   logic [TAG_W-1:0] wb_tag;
   logic             wb_ready;

   modport master (
      output lk_valid, lk_index, lk_tag, wr_op, wr_index, wr_tag, wr_dirty,
             flush_req, wb_ready,
      input  lk_ready, hit_valid, hit, hit_dirty, victim_tag, flush_busy,
             flush_done, wb_valid, wb_index, wb_tag
   );

   modport slave (
      input  lk_valid, lk_index, lk_tag, wr_op, wr_index, wr_tag, wr_dirty,
             flush_req, wb_ready,
      output lk_ready, hit_valid, hit, hit_dirty, victim_tag, flush_busy,
             flush_done, wb_valid, wb_index, wb_tag
   );
endinterface
`default_nettype wire

// File: rtl/dc_tag_array.sv
`default_nettype none
// ============================================================================
// Module   : dc_tag_array
// Purpose  : Tag/valid/dirty store for the data cache with a registered lookup
//            (hit, dirty and victim tag), encoded writes, a post-reset clear
//            sweep and a flush engine that hands dirty victims to the
//            write-back path over a valid/ready handshake.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            bus        - dc_tag_if.slave (lookup / write / flush / victim)
//            parity_err - parity error pulse (DC_TAG_PARITY_EN only)
// Options  : DC_TAG_PARITY_EN - adds an even-parity bit per entry, checked on
//            lookup and during flush.
// Revision : 1.0  initial release
// ============================================================================
module dc_tag_array #(
   parameter int NUM_SETS = 32,
   parameter int TAG_W    = 6,
   parameter int IDX_W    = 5
) (
   input  wire logic clk,
   input  wire logic rst_n,
   dc_tag_if.slave   bus
`ifdef DC_TAG_PARITY_EN
   ,
   output logic      parity_err
`endif
);

   localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

   typedef enum logic [1:0] {
      S_INIT    = 2'd0,
      S_IDLE    = 2'd1,
      S_FL_SCAN = 2'd2,
      S_FL_WB   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic               fl_pend_q, fl_pend_d;
   logic               done_q, done_d;

   logic [NUM_SETS-1:0] valid_q;
   logic [NUM_SETS-1:0] dirty_q;
   logic [TAG_W-1:0]    tag_q [NUM_SETS];

   logic               hit_valid_q, hit_q, hit_dirty_q, perr_q;
   logic [TAG_W-1:0]   victim_tag_q;

   logic               clr_en;   // clear entry cnt_q this cycle
   logic               adv;      // step the sweep to the next set
   logic               lk_acc;
   logic               lk_bad;   // addressed lookup entry fails parity
   logic               sc_bad;   // entry under the sweep fails parity
   logic               is_last;

   assign lk_acc  = (state_q == S_IDLE) && bus.lk_valid;
   assign is_last = (cnt_q == LAST_SET);

`ifdef DC_TAG_PARITY_EN
   logic [NUM_SETS-1:0] par_q;
   assign lk_bad = ^{par_q[bus.lk_index], valid_q[bus.lk_index],
                     dirty_q[bus.lk_index], tag_q[bus.lk_index]};
   assign sc_bad = ^{par_q[cnt_q], valid_q[cnt_q], dirty_q[cnt_q], tag_q[cnt_q]};
   assign parity_err = perr_q;
`else
   assign lk_bad = 1'b0;
   assign sc_bad = 1'b0;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_INIT;
         cnt_q     <= '0;
         fl_pend_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fl_pend_q <= fl_pend_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fl_pend_d = fl_pend_q;
      done_d    = 1'b0;
      clr_en    = 1'b0;
      adv       = 1'b0;
      case (state_q)
         S_INIT: begin
            clr_en = 1'b1;
            if (bus.flush_req) fl_pend_d = 1'b1;
            if (is_last) begin
               cnt_d     = '0;
               fl_pend_d = 1'b0;
               // A flush requested at any point of the clear sweep runs next.
               state_d   = (fl_pend_q || bus.flush_req) ? S_FL_SCAN : S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (bus.flush_req) begin
               state_d = S_FL_SCAN;
               cnt_d   = '0;
            end
         end
         S_FL_SCAN: begin
            // Corrupted entries are dropped rather than written back.
            if (valid_q[cnt_q] && dirty_q[cnt_q] && !sc_bad) begin
               state_d = S_FL_WB;
            end else begin
               clr_en = 1'b1;
               adv    = 1'b1;
            end
         end
         S_FL_WB: begin
            if (bus.wb_ready) begin
               clr_en = 1'b1;
               adv    = 1'b1;
            end
         end
         default: state_d = S_INIT;
      endcase
      if (adv) begin
         if (is_last) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
         end else begin
            state_d = S_FL_SCAN;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------ storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < NUM_SETS; i++) tag_q[i] <= '0;
`ifdef DC_TAG_PARITY_EN
         par_q   <= '0;
`endif
      end else if (clr_en) begin
         valid_q[cnt_q] <= 1'b0;
         dirty_q[cnt_q] <= 1'b0;
`ifdef DC_TAG_PARITY_EN
         par_q[cnt_q]   <= ^tag_q[cnt_q];
`endif
      end else if (state_q == S_IDLE) begin
         case (bus.wr_op)
            2'b01: begin
               valid_q[bus.wr_index] <= 1'b1;
               dirty_q[bus.wr_index] <= bus.wr_dirty;
               tag_q[bus.wr_index]   <= bus.wr_tag;
`ifdef DC_TAG_PARITY_EN
               par_q[bus.wr_index]   <= ^{1'b1, bus.wr_dirty, bus.wr_tag};
`endif
            end
            2'b10: begin
               if (valid_q[bus.wr_index]) begin
                  dirty_q[bus.wr_index] <= 1'b1;
`ifdef DC_TAG_PARITY_EN
                  par_q[bus.wr_index]   <= ^tag_q[bus.wr_index];
`endif
               end
            end
            2'b11: begin
               valid_q[bus.wr_index] <= 1'b0;
`ifdef DC_TAG_PARITY_EN
               par_q[bus.wr_index]   <= ^{dirty_q[bus.wr_index], tag_q[bus.wr_index]};
`endif
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------ lookup result
   // Reads see the array before this edge's write, so a same-cycle write to
   // the looked-up set is not reflected until the next lookup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_valid_q  <= 1'b0;
         hit_q        <= 1'b0;
         hit_dirty_q  <= 1'b0;
         victim_tag_q <= '0;
         perr_q       <= 1'b0;
      end else begin
         hit_valid_q <= lk_acc;
         perr_q      <= (lk_acc && lk_bad) || ((state_q == S_FL_SCAN) && sc_bad);
         if (lk_acc) begin
            hit_q        <= valid_q[bus.lk_index] && !lk_bad &&
                            (tag_q[bus.lk_index] == bus.lk_tag);
            hit_dirty_q  <= dirty_q[bus.lk_index];
            victim_tag_q <= tag_q[bus.lk_index];
         end
      end
   end

   // ------------------------------------------------------------ outputs
   assign bus.lk_ready   = (state_q == S_IDLE);
   assign bus.hit_valid  = hit_valid_q;
   assign bus.hit        = hit_q;
   assign bus.hit_dirty  = hit_dirty_q;
   assign bus.victim_tag = victim_tag_q;
   assign bus.flush_busy = (state_q == S_FL_SCAN) || (state_q == S_FL_WB);
   assign bus.flush_done = done_q;
   assign bus.wb_valid   = (state_q == S_FL_WB);
   assign bus.wb_index   = (state_q == S_FL_WB) ? cnt_q : '0;
   assign bus.wb_tag     = (state_q == S_FL_WB) ? tag_q[cnt_q] : '0;

endmodule
`default_nettype wire
